// File: rtl/sync_conditioner.sv
// -----------------------------------------------------------------------------
// sync_conditioner
//
// Multi-channel input conditioner for board-level asynchronous inputs
// (buttons, switches, external strobes). Each channel is brought into the clk
// domain by a STAGES-deep synchroniser chain, optionally debounced, and then
// presented as a registered clean level plus single-cycle rise/fall pulses.
//
// Build option:
//   SYNC_COND_DEBOUNCE_EN  defined   -> per-channel debounce counters present;
//                                       a new level must persist DB_CYCLES
//                                       consecutive cycles before clean follows.
//                          undefined -> no counters; clean follows the
//                                       synchroniser output every cycle and
//                                       busy is tied to 0.
//
// Parameters:
//   WIDTH      number of independent channels (>= 1)
//   STAGES     synchroniser depth per channel (>= 2)
//   DB_CYCLES  debounce hold time in cycles (>= 1), debounce build only
//
// Ports:
//   clk     in   1      single clock, rising edge
//   rst_n   in   1      asynchronous active-low reset, clears all state
//   sig_in  in   WIDTH  raw asynchronous inputs
//   clean   out  WIDTH  conditioned registered level
//   rise    out  WIDTH  one-cycle pulse in the first cycle clean[i] reads 1
//   fall    out  WIDTH  one-cycle pulse in the first cycle clean[i] reads 0
//   busy    out  WIDTH  debounce counter of channel i is nonzero
// -----------------------------------------------------------------------------
module sync_conditioner #(
    parameter int WIDTH     = 4,
    parameter int STAGES    = 2,
    parameter int DB_CYCLES = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] sig_in,
    output logic [WIDTH-1:0] clean,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall,
    output logic [WIDTH-1:0] busy
);

    // Wide enough to hold DB_CYCLES-1, the largest value the counter reaches.
    localparam int CNT_W = $clog2(DB_CYCLES + 1);

    if (WIDTH < 1 || STAGES < 2 || DB_CYCLES < 1 || CNT_W < 1) begin : g_param_check
        $error("sync_conditioner: illegal parameter set");
    end

    // ------------------------------------------------------------------
    // Synchroniser: plain shift chain, nothing between stages so every
    // stage gets the full cycle to resolve metastability.
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] sync_q [STAGES];
    logic [WIDTH-1:0] sync_d [STAGES];
    logic [WIDTH-1:0] s;

    always_comb begin
        sync_d[0] = sig_in;
        for (int k = 1; k < STAGES; k++) begin
            sync_d[k] = sync_q[k-1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < STAGES; k++) begin
                sync_q[k] <= '0;
            end
        end else begin
            for (int k = 0; k < STAGES; k++) begin
                sync_q[k] <= sync_d[k];
            end
        end
    end

    assign s = sync_q[STAGES-1];

    // ------------------------------------------------------------------
    // Level qualification
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] clean_d, clean_q;
    logic [WIDTH-1:0] rise_d,  rise_q;
    logic [WIDTH-1:0] fall_d,  fall_q;

`ifdef SYNC_COND_DEBOUNCE_EN
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q [WIDTH];
    logic [CNT_W-1:0] cnt_d [WIDTH];

    // Counter tracks how long s has disagreed with clean. Any agreement
    // drops it back to 0, so only an uninterrupted run of DB_CYCLES
    // mismatching cycles moves clean. Reaching CNT_LAST commits the new
    // level and recycles to 0, so the counter never wraps.
    always_comb begin
        clean_d = clean_q;
        for (int i = 0; i < WIDTH; i++) begin
            cnt_d[i] = '0;
            if (s[i] != clean_q[i]) begin
                if (cnt_q[i] == CNT_LAST) begin
                    clean_d[i] = s[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < WIDTH; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < WIDTH; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    always_comb begin
        busy = '0;
        for (int i = 0; i < WIDTH; i++) begin
            busy[i] = (cnt_q[i] != '0);
        end
    end
`else
    // No filtering: clean simply follows the synchroniser one cycle later.
    assign clean_d = s;
    assign busy    = '0;
`endif

    // Pulses are computed from the next and current clean value so they
    // land in the same cycle as the new clean level. A channel can only
    // change in one direction per edge, so rise and fall are exclusive.
    assign rise_d = clean_d & ~clean_q;
    assign fall_d = clean_q & ~clean_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clean_q <= '0;
            rise_q  <= '0;
            fall_q  <= '0;
        end else begin
            clean_q <= clean_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end

    assign clean = clean_q;
    assign rise  = rise_q;
    assign fall  = fall_q;

endmodule

// File: doc/sync_conditioner.md
# sync_conditioner

Parametrised multi-channel input conditioner: each of WIDTH asynchronous inputs passes through a STAGES-deep synchroniser, then an optional per-channel debounce filter, and produces a clean level plus single-cycle rise/fall pulses. It sits between board-level inputs (buttons, switches, external strobes) and the multiplier control FSM. It replaces the fixed single-bit two-flop synchroniser used so far.

## Interface
Parameters:
- WIDTH, 4, number of independent channels (≥1)
- STAGES, 2, synchroniser flop depth per channel (≥2)
- DB_CYCLES, 16, consecutive cycles a new synchronised level must hold before `clean` accepts it (≥1). Only used when debounce is compiled in.
- CNT_W, derived localparam = $clog2(DB_CYCLES+1). Not user-set.

Ports:
- clk  in  1  single clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- sig_in  in  WIDTH  raw asynchronous inputs
- clean  out  WIDTH  conditioned registered level per channel
- rise  out  WIDTH  one-cycle pulse, high in the first cycle `clean[i]` reads 1
- fall  out  WIDTH  one-cycle pulse, high in the first cycle `clean[i]` reads 0
- busy  out  WIDTH  `busy[i]` = 1 while channel i's debounce counter is nonzero. Tied to 0 without debounce.

## Operation
- Reset (rst_n low, asynchronous): all synchroniser flops, counters, `clean`, `rise`, `fall`, and `busy` go to 0 immediately. They stay 0 while rst_n is low.
- Synchroniser: per channel, a shift chain of STAGES flops. `s[i]` denotes the last stage. No logic is allowed between stages.
- Debounce, per channel, evaluated every edge:
  - If `s[i]` == `clean[i]`: counter <= 0, and `clean[i]` is held.
  - Else if counter == DB_CYCLES-1: `clean[i]` <= `s[i]` and counter <= 0.
  - Else: counter <= counter+1.
- Effect of the debounce rule: a mismatch shorter than DB_CYCLES consecutive cycles is discarded. `clean` does not change and no pulse is produced. Any return to agreement restarts the count from 0.
- Pulses: `rise[i]` and `fall[i]` are registered alongside `clean[i]`. They are asserted in exactly the cycle following the edge on which `clean[i]` changes, and deasserted on the next edge. `rise` and `fall` are never both high on a channel.
- Channels are fully independent. Simultaneous changes on several channels produce simultaneous pulses.
- Counter width is CNT_W. The counter never exceeds DB_CYCLES-1, so it cannot wrap.
- Reset released with sig_in already high: this is treated as a normal 0→1 transition. After the full latency, a `rise` pulse is produced.

## Timing
- The edge that first samples a new sig_in level is E0.
- `s[i]` reflects the new level after edge E(STAGES-1).
- With debounce, `clean[i]` and its pulse are visible after edge E(STAGES+DB_CYCLES-1). This is a latency of STAGES+DB_CYCLES edges.
- Without debounce, `clean[i]` and its pulse are visible after edge E(STAGES), a latency of STAGES+1 edges.
- Minimum spacing between pulses on one channel is DB_CYCLES cycles with debounce, and 1 cycle without.
- Reset asserted mid-count: counter and outputs are cleared at once. No pulse is emitted for the interrupted transition.

## Configuration
- Macro: SYNC_COND_DEBOUNCE_EN.
- Defined: debounce counters are present and behave as above, and `busy` is live.
- Undefined: no counters are instantiated, DB_CYCLES is ignored, and `busy` = 0. Each edge does `clean[i]` <= `s[i]`, equivalent to DB_CYCLES=1. Pulse rules are unchanged.

## Test plan
(WIDTH=4, STAGES=2, DB_CYCLES=4, debounce enabled unless stated.)
- Reset check: hold rst_n=0 with sig_in=4'hF. Required: clean, rise, fall, and busy all read 0. Assert rst_n=0 asynchronously between edges and confirm the outputs clear without waiting for an edge.
- Step response: sig_in[0] 0→1 before E0 and held. Required: `busy[0]`=1 from after E2, `clean[0]`=1 and `rise[0]`=1 after E5, `rise[0]`=0 after E6. Then sig_in[0] 1→0 produces `fall[0]` with the same latency.
- Glitch rejection: sig_in[1] high for 3 cycles, then low. Required: `clean[1]` stays 0, no rise/fall, and `busy[1]` returns to 0.
- Simultaneous channels: sig_in 4'h0→4'hA on one edge. Required: `rise` == 4'hA for exactly one cycle, and `rise[0]`/`rise[2]` never assert.
- Reset mid-operation: pull rst_n low when `busy[0]`=1 (count 2). Then release with sig_in[0] still 1. Required: all outputs 0 during reset, then a fresh `rise[0]` 6 edges after the first post-reset edge.
- Macro undefined: repeat the step test. Required: `clean[0]`/`rise[0]` after E2, `busy` always 0, and a 1-cycle glitch passes through as rise followed by fall.
